// File: rtl/pb_field_encoder_if.sv
// Handshake bundle for the protobuf field encoder: request side (in_*),
// byte stream side (out_*), plus the reject pulse and the emitted-byte counter.
interface pb_field_encoder_if #(
    parameter int FIELD_NUM_W = 29
);
    logic                   in_valid;
    logic                   in_ready;
    logic [FIELD_NUM_W-1:0] in_field_number;
    logic [2:0]             in_wire_type;
    logic [63:0]            in_value;
    logic                   in_zigzag;
    logic                   out_valid;
    logic                   out_ready;
    logic [7:0]             out_data;
    logic                   out_last;
    logic                   err_illegal;
    logic [31:0]            bytes_emitted;

    modport master (
        output in_valid, in_field_number, in_wire_type, in_value, in_zigzag, out_ready,
        input  in_ready, out_valid, out_data, out_last, err_illegal, bytes_emitted
    );

    modport slave (
        input  in_valid, in_field_number, in_wire_type, in_value, in_zigzag, out_ready,
        output in_ready, out_valid, out_data, out_last, err_illegal, bytes_emitted
    );
endinterface

// File: rtl/pb_field_encoder.sv
// Protobuf field encoder: emits varint key then varint/fixed64/fixed32 payload bytes.
// Optional macro PB_ENC_ZIGZAG_EN enables the sint (zigzag) transform on varint payloads.
module pb_field_encoder #(
    parameter int FIELD_NUM_W = 29
) (
    input logic                clk,
    input logic                rst,
    pb_field_encoder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, KEY, PAYLOAD} state_t;

    state_t      state;
    logic        out_valid_r;
    logic [7:0]  out_data_r;
    logic        out_last_r;
    logic        err_r;
    logic [31:0] count_r;

    // Remaining bits after the byte currently on out_data
    logic [31:0] key_rem;
    logic [63:0] pay_rem;
    logic        is_fixed;
    logic [3:0]  fix_cnt;

    logic [FIELD_NUM_W-1:0] fn;
    logic [31:0]            key_c;
    logic [63:0]            pay_c;
    logic                   legal_c;
    logic                   hs;
    logic                   key_more;
    logic [7:0]             key_byte;
    logic [7:0]             pay_byte;
    logic                   pay_last;
    logic [63:0]            pay_shift;

    function automatic logic [7:0] varint_byte(input logic [63:0] v);
        return {|v[63:7], v[6:0]};
    endfunction

`ifdef PB_ENC_ZIGZAG_EN
    function automatic logic [63:0] zigzag(input logic [63:0] v);
        logic signed [63:0] s;
        s = v;
        return (v << 1) ^ 64'(s >>> 63);
    endfunction
`endif

    assign fn      = bus.in_field_number;
    assign key_c   = (32'(fn) << 3) | {29'd0, bus.in_wire_type};
    assign legal_c = ((bus.in_wire_type == 3'd0) || (bus.in_wire_type == 3'd1) ||
                      (bus.in_wire_type == 3'd5)) && (fn != '0);

`ifdef PB_ENC_ZIGZAG_EN
    assign pay_c = ((bus.in_wire_type == 3'd0) && bus.in_zigzag) ? zigzag(bus.in_value)
                                                                  : bus.in_value;
`else
    logic unused_zigzag;
    assign unused_zigzag = bus.in_zigzag;
    assign pay_c         = bus.in_value;
`endif

    assign hs       = out_valid_r && bus.out_ready;
    assign key_more = (key_rem != 32'd0);
    assign key_byte = varint_byte({32'd0, key_rem});

    always_comb begin
        pay_byte  = is_fixed ? pay_rem[7:0] : varint_byte(pay_rem);
        pay_last  = is_fixed ? (fix_cnt == 4'd1) : (pay_rem[63:7] == 57'd0);
        pay_shift = is_fixed ? (pay_rem >> 8) : (pay_rem >> 7);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
            out_data_r  <= 8'd0;
            out_last_r  <= 1'b0;
            err_r       <= 1'b0;
            count_r     <= 32'd0;
        end else begin
            err_r <= 1'b0;
            if (hs) count_r <= count_r + 32'd1;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (legal_c) begin
                            state       <= KEY;
                            out_valid_r <= 1'b1;
                            out_data_r  <= varint_byte({32'd0, key_c});
                            out_last_r  <= 1'b0;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                end
                KEY: begin
                    if (hs) begin
                        if (key_more) begin
                            out_data_r <= key_byte;
                        end else begin
                            state      <= PAYLOAD;
                            out_data_r <= pay_byte;
                            out_last_r <= pay_last;
                        end
                    end
                end
                PAYLOAD: begin
                    if (hs) begin
                        if (out_last_r) begin
                            state       <= IDLE;
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                        end else begin
                            out_data_r <= pay_byte;
                            out_last_r <= pay_last;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Shift registers carry no reset: they are reloaded on every accept
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    key_rem  <= key_c >> 7;
                    pay_rem  <= pay_c;
                    is_fixed <= (bus.in_wire_type != 3'd0);
                    fix_cnt  <= (bus.in_wire_type == 3'd1) ? 4'd8 : 4'd4;
                end
            end
            KEY: begin
                if (hs) begin
                    if (key_more) begin
                        key_rem <= key_rem >> 7;
                    end else begin
                        pay_rem <= pay_shift;
                        fix_cnt <= fix_cnt - 4'd1;
                    end
                end
            end
            PAYLOAD: begin
                if (hs && !out_last_r) begin
                    pay_rem <= pay_shift;
                    fix_cnt <= fix_cnt - 4'd1;
                end
            end
            default: ;
        endcase
    end

    assign bus.in_ready      = (state == IDLE);
    assign bus.out_valid     = out_valid_r;
    assign bus.out_data      = out_data_r;
    assign bus.out_last      = out_last_r;
    assign bus.err_illegal   = err_r;
    assign bus.bytes_emitted = count_r;
endmodule

// File: tb/tb_pb_field_encoder.sv
// Directed bench for pb_field_encoder: reset, varint/fixed encodings, backpressure,
// zigzag, illegal requests, mid-field reset and back-to-back fields.
module tb_pb_field_encoder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pb_field_encoder_if #(.FIELD_NUM_W(29)) bus ();
    pb_field_encoder #(.FIELD_NUM_W(29)) dut (.clk(clk), .rst(rst), .bus(bus));

    int vectors     = 0;
    int miscompares = 0;
    int exp_total   = 0;

    logic [7:0] cap_data [0:15];
    logic       cap_last [0:15];
    int         cap_n;
    int         cap_cycles;
    bit         cap_timeout;

    task automatic drive_idle();
        bus.in_valid        = 1'b0;
        bus.in_field_number = '0;
        bus.in_wire_type    = 3'd0;
        bus.in_value        = 64'd0;
        bus.in_zigzag       = 1'b0;
        bus.out_ready       = 1'b1;
    endtask

    task automatic send(input logic [28:0] fnum, input logic [2:0] wt,
                        input logic [63:0] v, input logic zz);
        bus.in_valid        = 1'b1;
        bus.in_field_number = fnum;
        bus.in_wire_type    = wt;
        bus.in_value        = v;
        bus.in_zigzag       = zz;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Records handshaken bytes until the out_last handshake or the cycle budget runs out
    task automatic capture();
        for (int i = 0; i < 16; i++) begin
            cap_data[i] = 8'hxx;
            cap_last[i] = 1'bx;
        end
        cap_n = 0; cap_cycles = 0; cap_timeout = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (bus.out_valid && bus.out_ready) begin
                if (cap_n < 16) begin
                    cap_data[cap_n] = bus.out_data;
                    cap_last[cap_n] = bus.out_last;
                end
                cap_n++;
                if (bus.out_last) begin
                    cap_timeout = 1'b0;
                    cap_cycles  = c + 1;
                    @(posedge clk); #1;
                    break;
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        #3;
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset out_valid: got %b need 0", bus.out_valid); end
        vectors++; if (bus.out_data !== 8'h00) begin miscompares++; $display("FAIL reset out_data: got %h need 00", bus.out_data); end
        vectors++; if (bus.out_last !== 1'b0) begin miscompares++; $display("FAIL reset out_last: got %b need 0", bus.out_last); end
        vectors++; if (bus.err_illegal !== 1'b0) begin miscompares++; $display("FAIL reset err_illegal: got %b need 0", bus.err_illegal); end
        vectors++; if (bus.bytes_emitted !== 32'd0) begin miscompares++; $display("FAIL reset bytes_emitted: got %0d need 0", bus.bytes_emitted); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset in_ready: got %b need 1", bus.in_ready); end
        exp_total = 0;
    endtask

    task automatic test_varint();
        logic [7:0] e [0:2];
        e = '{8'h08, 8'h96, 8'h01};
        send(29'd1, 3'd0, 64'd150, 1'b0);
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL varint in_ready_busy: got %b need 0", bus.in_ready); end
        capture();
        vectors++; if (cap_timeout || cap_n !== 3) begin miscompares++; $display("FAIL varint count: got %0d timeout %b need 3", cap_n, cap_timeout); end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (cap_data[i] !== e[i] || cap_last[i] !== (i == 2)) begin
                miscompares++; $display("FAIL varint byte%0d: got %h last %b need %h last %b", i, cap_data[i], cap_last[i], e[i], (i == 2));
            end
        end
        vectors++; if (cap_cycles !== 3) begin miscompares++; $display("FAIL varint cycles: got %0d need 3", cap_cycles); end
        exp_total += 3;
        vectors++; if (bus.bytes_emitted !== 32'(exp_total)) begin miscompares++; $display("FAIL varint bytes_emitted: got %0d need %0d", bus.bytes_emitted, exp_total); end
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL varint in_ready_after: got %b need 1", bus.in_ready); end
    endtask

    task automatic test_fixed64();
        // key (16<<3)|1 = 0x81 encodes as 81 01
        logic [7:0] e [0:9];
        e = '{8'h81, 8'h01, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
        send(29'd16, 3'd1, 64'h0102030405060708, 1'b0);
        capture();
        vectors++; if (cap_timeout || cap_n !== 10) begin miscompares++; $display("FAIL fixed64 count: got %0d timeout %b need 10", cap_n, cap_timeout); end
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (cap_data[i] !== e[i] || cap_last[i] !== (i == 9)) begin
                miscompares++; $display("FAIL fixed64 byte%0d: got %h last %b need %h last %b", i, cap_data[i], cap_last[i], e[i], (i == 9));
            end
        end
        vectors++; if (cap_cycles !== 10) begin miscompares++; $display("FAIL fixed64 cycles: got %0d need 10", cap_cycles); end
        exp_total += 10;
        vectors++; if (bus.bytes_emitted !== 32'(exp_total)) begin miscompares++; $display("FAIL fixed64 bytes_emitted: got %0d need %0d", bus.bytes_emitted, exp_total); end
    endtask

    task automatic test_fixed32_backpressure();
        logic [7:0] e [0:4];
        e = '{8'h15, 8'h00, 8'h00, 8'h80, 8'h3F};
        bus.out_ready = 1'b0;
        send(29'd2, 3'd5, 64'h000000003F800000, 1'b0);
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h15 || bus.out_last !== 1'b0) begin
                miscompares++; $display("FAIL fixed32 hold%0d: got v%b %h l%b need v1 15 l0", c, bus.out_valid, bus.out_data, bus.out_last);
            end
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        capture();
        vectors++; if (cap_timeout || cap_n !== 5) begin miscompares++; $display("FAIL fixed32 count: got %0d timeout %b need 5", cap_n, cap_timeout); end
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (cap_data[i] !== e[i] || cap_last[i] !== (i == 4)) begin
                miscompares++; $display("FAIL fixed32 byte%0d: got %h last %b need %h last %b", i, cap_data[i], cap_last[i], e[i], (i == 4));
            end
        end
        exp_total += 5;
        vectors++; if (bus.bytes_emitted !== 32'(exp_total)) begin miscompares++; $display("FAIL fixed32 bytes_emitted: got %0d need %0d", bus.bytes_emitted, exp_total); end
    endtask

    task automatic test_zigzag();
        logic [7:0] e [0:10];
        int         n;
`ifdef PB_ENC_ZIGZAG_EN
        e = '{8'h08, 8'h01, default: 8'h00};
        n = 2;
`else
        e = '{8'h08, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
        n = 11;
`endif
        send(29'd1, 3'd0, 64'hFFFFFFFFFFFFFFFF, 1'b1);
        capture();
        vectors++; if (cap_timeout || cap_n !== n) begin miscompares++; $display("FAIL zigzag count: got %0d timeout %b need %0d", cap_n, cap_timeout, n); end
        for (int i = 0; i < n; i++) begin
            vectors++;
            if (cap_data[i] !== e[i] || cap_last[i] !== (i == n - 1)) begin
                miscompares++; $display("FAIL zigzag byte%0d: got %h last %b need %h last %b", i, cap_data[i], cap_last[i], e[i], (i == n - 1));
            end
        end
        exp_total += n;
        vectors++; if (bus.bytes_emitted !== 32'(exp_total)) begin miscompares++; $display("FAIL zigzag bytes_emitted: got %0d need %0d", bus.bytes_emitted, exp_total); end
    endtask

    task automatic test_max_key();
        // field 0x1FFFFFFF wt 0: key 0xFFFFFFF8 is a full 5-byte varint
        logic [7:0] e [0:5];
        e = '{8'hF8, 8'hFF, 8'hFF, 8'hFF, 8'h0F, 8'h01};
        send(29'h1FFFFFFF, 3'd0, 64'd1, 1'b0);
        capture();
        vectors++; if (cap_timeout || cap_n !== 6) begin miscompares++; $display("FAIL maxkey count: got %0d timeout %b need 6", cap_n, cap_timeout); end
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (cap_data[i] !== e[i] || cap_last[i] !== (i == 5)) begin
                miscompares++; $display("FAIL maxkey byte%0d: got %h last %b need %h last %b", i, cap_data[i], cap_last[i], e[i], (i == 5));
            end
        end
        exp_total += 6;
    endtask

    task automatic test_illegal();
        logic [28:0] fnums [0:1];
        logic [2:0]  wts   [0:1];
        fnums = '{29'd1, 29'd0};
        wts   = '{3'd2, 3'd0};
        for (int k = 0; k < 2; k++) begin
            send(fnums[k], wts[k], 64'h55, 1'b0);
            vectors++;
            if (bus.err_illegal !== 1'b1 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                miscompares++; $display("FAIL illegal%0d pulse: got err %b v %b rdy %b need 1 0 1", k, bus.err_illegal, bus.out_valid, bus.in_ready);
            end
            @(posedge clk); #1;
            vectors++;
            if (bus.err_illegal !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                miscompares++; $display("FAIL illegal%0d after: got err %b v %b rdy %b need 0 0 1", k, bus.err_illegal, bus.out_valid, bus.in_ready);
            end
            vectors++; if (bus.bytes_emitted !== 32'(exp_total)) begin miscompares++; $display("FAIL illegal%0d bytes_emitted: got %0d need %0d", k, bus.bytes_emitted, exp_total); end
        end
    endtask

    task automatic test_reset_midfield();
        send(29'd1, 3'd0, 64'd150, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        vectors++; if (bus.out_data !== 8'h01 || bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL midrst third_byte: got %h v %b need 01 v 1", bus.out_data, bus.out_valid); end
        rst = 1'b1;
        #1;
        vectors++; if (bus.out_valid !== 1'b0 || bus.bytes_emitted !== 32'd0) begin miscompares++; $display("FAIL midrst async: got v %b count %0d need v 0 count 0", bus.out_valid, bus.bytes_emitted); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        vectors++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL midrst dropped: got v %b rdy %b need v 0 rdy 1", bus.out_valid, bus.in_ready); end
        exp_total = 0;
        send(29'd1, 3'd0, 64'd0, 1'b0);
        capture();
        vectors++; if (cap_timeout || cap_n !== 2) begin miscompares++; $display("FAIL midrst count: got %0d timeout %b need 2", cap_n, cap_timeout); end
        vectors++; if (cap_data[0] !== 8'h08 || cap_last[0] !== 1'b0) begin miscompares++; $display("FAIL midrst byte0: got %h last %b need 08 last 0", cap_data[0], cap_last[0]); end
        vectors++; if (cap_data[1] !== 8'h00 || cap_last[1] !== 1'b1) begin miscompares++; $display("FAIL midrst byte1: got %h last %b need 00 last 1", cap_data[1], cap_last[1]); end
        exp_total += 2;
        vectors++; if (bus.bytes_emitted !== 32'(exp_total)) begin miscompares++; $display("FAIL midrst bytes_emitted: got %0d need %0d", bus.bytes_emitted, exp_total); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e1 [0:2];
        logic [7:0] e2 [0:4];
        e1 = '{8'h18, 8'hAC, 8'h02};
        e2 = '{8'h25, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send(29'd3, 3'd0, 64'd300, 1'b0);
        capture();
        vectors++; if (cap_timeout || cap_n !== 3) begin miscompares++; $display("FAIL b2b first_count: got %0d timeout %b need 3", cap_n, cap_timeout); end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (cap_data[i] !== e1[i] || cap_last[i] !== (i == 2)) begin
                miscompares++; $display("FAIL b2b first byte%0d: got %h last %b need %h last %b", i, cap_data[i], cap_last[i], e1[i], (i == 2));
            end
        end
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b in_ready: got %b need 1", bus.in_ready); end
        send(29'd4, 3'd5, 64'hFFFFFFFFDEADBEEF, 1'b0);
        capture();
        vectors++; if (cap_timeout || cap_n !== 5) begin miscompares++; $display("FAIL b2b second_count: got %0d timeout %b need 5", cap_n, cap_timeout); end
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (cap_data[i] !== e2[i] || cap_last[i] !== (i == 4)) begin
                miscompares++; $display("FAIL b2b second byte%0d: got %h last %b need %h last %b", i, cap_data[i], cap_last[i], e2[i], (i == 4));
            end
        end
        exp_total += 8;
        vectors++; if (bus.bytes_emitted !== 32'(exp_total)) begin miscompares++; $display("FAIL b2b bytes_emitted: got %0d need %0d", bus.bytes_emitted, exp_total); end
    endtask

    initial begin
        test_reset();
        test_varint();
        test_fixed64();
        test_fixed32_backpressure();
        test_zigzag();
        test_max_key();
        test_illegal();
        test_reset_midfield();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
